// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for the EX stage.
// Serves DIV (signed) and DIVU (unsigned). The result is packed as
// {HI = remainder, LO = quotient} for the HI/LO write path.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active-high
//   start_i    request a division (sampled only in IDLE)
//   signed_i   1 = DIV (two's complement), 0 = DIVU
//   opdata1_i  dividend
//   opdata2_i  divisor
//   annul_i    flush; aborts the operation in progress, beats start_i
//   result_o   {remainder, quotient}, valid while ready_o = 1
//   ready_o    result valid (registered)
//   busy_o     high in BYZERO and ON; the pipeline stalls on it
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W:0]   shreg;
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   dividend_raw;
    logic                neg_quo;
    logic                neg_rem;
    logic [2*DATA_W-1:0] final_res;

    logic [DATA_W-1:0]   op1_abs;
    logic [DATA_W-1:0]   op2_abs;
    logic [2*DATA_W:0]   shifted;
    logic [DATA_W:0]     trial;
    logic [2*DATA_W:0]   step;
    logic [DATA_W-1:0]   step_quo;
    logic [DATA_W-1:0]   step_rem;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. annul_i wins over start_i everywhere; in END the
    // FSM stays put while the pipeline keeps start_i high so the same
    // instruction cannot launch a second division.
    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    state_next = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                busy_o     = 1'b1;
                state_next = annul_i ? S_IDLE : S_END;
            end
            S_ON: begin
                busy_o = 1'b1;
                if (annul_i) begin
                    state_next = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_END;
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand magnitudes; negating the most negative value wraps back to
    // itself, which is the correct unsigned magnitude.
    always_comb begin
        op1_abs = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        op2_abs = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    end

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor
    // from the remainder half, keep the difference when it did not borrow.
    // The final step's result also feeds the sign fixup used on END entry.
    always_comb begin
        shifted = shreg << 1;
        trial   = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
        step    = shifted;
        if (!trial[DATA_W]) begin
            step = {trial, shifted[DATA_W-1:1], 1'b1};
        end
        step_quo = step[DATA_W-1:0];
        step_rem = step[2*DATA_W-1:DATA_W];
        quo_fix  = neg_quo ? -step_quo : step_quo;
        rem_fix  = neg_rem ? -step_rem : step_rem;
    end

    // Datapath and registered outputs. ready_o/result_o rise on the first
    // edge spent in END, so the result appears one cycle after END entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            shreg        <= '0;
            divisor      <= '0;
            dividend_raw <= '0;
            neg_quo      <= 1'b0;
            neg_rem      <= 1'b0;
            final_res    <= '0;
            result_o     <= '0;
            ready_o      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        cnt          <= '0;
                        shreg        <= {{(DATA_W+1){1'b0}}, op1_abs};
                        divisor      <= op2_abs;
                        dividend_raw <= opdata1_i;
                        neg_quo      <= signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_rem      <= signed_i && opdata1_i[DATA_W-1];
                    end
                end
                S_BYZERO: begin
                    if (!annul_i) begin
                        final_res <= {dividend_raw, {DATA_W{1'b1}}};
                    end
                end
                S_ON: begin
                    if (!annul_i) begin
                        shreg <= step;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            final_res <= {rem_fix, quo_fix};
                        end
                    end
                end
                S_END: begin
                    if (annul_i || !start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else begin
                        ready_o  <= 1'b1;
                        result_o <= final_res;
                    end
                end
                default: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq. Directed cases plus
// randomized DIV/DIVU operations compared against an arithmetic model.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int checks;
    int errors;

    div_seq #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: {remainder, quotient} from plain integer arithmetic.
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (!sgn) return {a % b, a / b};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Launches one operation (called #1 after a rising edge), checks latency,
    // busy duration and result, holds start for extra END cycles, then drops
    // start and checks that the outputs clear.
    task automatic applyStimulus(input string tag, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input int hold_cycles);
        logic [63:0] exp_res;
        int lat;
        int busy_cnt;
        exp_res   = refDiv(sgn, a, b);
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        @(posedge clk); #1;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~sgn;
        lat = 0;
        busy_cnt = 0;
        while (!ready_o && lat < 40) begin
            if (busy_o) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, " latency"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        checkOutput({tag, " busy cycles"}, 64'(busy_cnt), (b == 32'd0) ? 64'd1 : 64'd32);
        checkOutput({tag, " result"}, result_o, exp_res);
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk); #1;
            checkOutput({tag, " hold state"}, {61'd0, ready_o, busy_o, 1'b0}, 64'b100);
            checkOutput({tag, " hold result"}, result_o, exp_res);
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, " drop ready/busy"}, {62'd0, ready_o, busy_o}, 64'd0);
        checkOutput({tag, " drop result"}, result_o, 64'd0);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset outputs", {result_o[61:0], ready_o, busy_o}, 64'd0);
        checkOutput("reset result", result_o, 64'd0);
        rst = 1'b0;

        // Directed cases.
        applyStimulus("divu 100/7", 1'b0, 32'd100, 32'd7, 0);
        applyStimulus("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 1);
        applyStimulus("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 0);
        applyStimulus("div overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
        applyStimulus("divu max/1", 1'b0, 32'hFFFFFFFF, 32'd1, 0);
        applyStimulus("div by zero", 1'b0, 32'h1234, 32'd0, 1);
        applyStimulus("div min/3", 1'b1, 32'h80000000, 32'd3, 0);

        // annul_i in IDLE blocks acceptance.
        start_i   = 1'b1;
        annul_i   = 1'b1;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        @(posedge clk); #1;
        start_i = 1'b0;
        annul_i = 1'b0;
        checkOutput("idle annul blocks", {62'd0, ready_o, busy_o}, 64'd0);

        // annul_i on ON cycle 10 aborts; ready never rises.
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("annul busy before", {63'd0, busy_o}, 64'd1);
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        checkOutput("annul to idle", {62'd0, ready_o, busy_o}, 64'd0);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("annul no ready", {62'd0, ready_o, busy_o}, 64'd0);
        applyStimulus("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, 0);

        // Reset in the middle of ON.
        start_i   = 1'b1;
        signed_i  = 1'b1;
        opdata1_i = 32'hFFFF0000;
        opdata2_i = 32'd17;
        @(posedge clk); #1;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        start_i = 1'b0;
        checkOutput("mid-op reset flags", {62'd0, ready_o, busy_o}, 64'd0);
        checkOutput("mid-op reset result", result_o, 64'd0);
        applyStimulus("after reset hold 5", 1'b0, 32'd123456, 32'd789, 5);

        // Randomized operations.
        for (int n = 0; n < 20; n++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 3))
                0: b = b & 32'h0000000F;
                1: b = b & 32'h0000FFFF;
                default: ;
            endcase
            if (b == 32'd0) begin
                a   = a & 32'h7FFFFFFF;
                sgn = 1'b0;
            end
            applyStimulus("random", sgn, a, b, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
